nes_ctlr_port: RTL and testbench
================================

# nes_ctlr_port

Models one NES standard controller, the 4021-style parallel-in/serial-out responder, on the serial joypad interface driven by `cpu_memory`. It synchronizes and debounces eight raw board buttons, applies optional turbo to A/B, and answers the CPU's $4016 strobe and per-read clock pulses with the serial `ctlr_data` bit. Two instances, one per port, drive `ctlr_data_p1` and `ctlr_data_p2` of `cpu_memory`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: master-clock cycles an input must stay stable before the debounced value changes.
- `TURBO_DIV`, default 4: number of NES frames (`frame_tick` pulses) per turbo half-period.
- `clock`  in  1  master clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `clock_en`  in  1  CPU clock enable (master/12). Shift and latch events are qualified by it.
- `frame_tick`  in  1  one-cycle pulse per frame (vblank start), turbo time base.
- `buttons_raw`  in  8  asynchronous, active-high buttons. Bits 0..7 = A, B, Select, Start, Up, Down, Left, Right.
- `turbo_en`  in  2  bit0 turbo A, bit1 turbo B. Asynchronous level.
- `ctlr_latch`  in  1  $4016 bit0 strobe level, synchronous to `clock`.
- `ctlr_pulse`  in  1  one-cycle read strobe from `cpu_memory` for this port's register.
- `ctlr_data`  out  1  serial bit, active-low: 0 = pressed, 1 = released or exhausted.
- `btn_state`  out  8  debounced, turbo-applied, active-high button vector, for debug.

## Operation
- Input path per bit: 2-flop synchronizer, then debouncer. The debounced value updates only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive clocks. The counter clears whenever the input equals the current value.
- Turbo: a frame counter counts `frame_tick` pulses modulo `TURBO_DIV` and toggles `turbo_phase` at wrap.
  - `btn_state[0] = deb[0] & (~turbo_en[0] | turbo_phase)`.
  - `btn_state[1]` is formed the same way with `turbo_en[1]`.
  - Other bits equal `deb`.
- Shift register `sr[7:0]` holds active-low data. `ctlr_data = sr[0]`.
- Event rules, evaluated only when `clock_en` = 1:
  - LOAD when `ctlr_latch` = 1: `sr <= ~btn_state`. This reloads every enabled cycle while the strobe stays high, so `ctlr_data` tracks A live.
  - SHIFT when `ctlr_latch` = 0 and `ctlr_pulse` = 1: `sr <= {1'b1, sr[7:1]}`.
  - LOAD and `ctlr_pulse` together: LOAD wins and no shift occurs; `ctlr_data` shows A.
  - Reads beyond 8: `ctlr_data` = 1 indefinitely until the next LOAD.
  - `ctlr_pulse` with `clock_en` = 0 is ignored. `cpu_memory` asserts it aligned to `clock_en`.
- Shifts use the register content at the pulse. The value read by the CPU on a pulse is the pre-shift `sr[0]`.

## Timing
- Reset values:
  - `sr` = 8'hFF, so `ctlr_data` = 1.
  - `btn_state` = 0, synchronizers = 0, debounce counters = 0.
  - `turbo_phase` = 1, frame counter = 0.
- Button latency from `buttons_raw` to `btn_state`: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 register stage = 19 clocks at default.
- LOAD and SHIFT take effect on the `clock` edge where `clock_en` is sampled high. `ctlr_data` changes the following cycle.
- Reset mid-sequence: `sr` returns to FF immediately; debounce restarts from released.
- Debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits and saturates. Frame counter is `$clog2(TURBO_DIV)` bits and wraps at `TURBO_DIV`-1.

## Structure
- Add to the shared package (next to `ppu_defines`): the `ctlr_btn_e` index enum (A=0 … RIGHT=7) and the `CTLR_RELEASED` = 8'hFF constant.
- One sub-module, `btn_debounce`: synchronizer + debouncer, parameterized on `DEBOUNCE_CYCLES`, 1-bit. Instantiated 10 times: 8 buttons + 2 turbo enables. Turbo enables use the sync stage only, via parameter `DEBOUNCE_CYCLES`=0.

## Test plan
- Reset with `buttons_raw`=8'h00 → `ctlr_data`=1, `btn_state`=0. 8 pulses after latch → eight 1s.
- Hold `buttons_raw`=8'h09 (A, Start) ≥ 20 clocks; latch 1→0; 8 pulses → pre-shift reads 0,1,1,0,1,1,1,1. Ninth and tenth reads → 1,1.
- Bounce: toggle `buttons_raw[4]` every 5 clocks for 100 clocks, then hold 1 → `btn_state[4]` stays 0 during bouncing and goes to 1 exactly 19 clocks after the final edge.
- Latch held high, change A pressed/released → `ctlr_data` follows ~A one enabled cycle later. `ctlr_pulse` during latch high → no shift; 8 subsequent reads after release still start at A.
- Turbo: `turbo_en`=2'b01, A held, `TURBO_DIV`=4 → `btn_state[0]` alternates 4 frames 1 and 4 frames 0, starting at 1. B is unaffected.
- Assert `reset_n` low after 3 of 8 reads → `ctlr_data`=1 asynchronously. Next latch+reads return fresh debounced data, all 1s until buttons have been held ≥ 19 clocks.

Source files
------------

// File: rtl/nes_ctlr_port_pkg.sv
// Shared controller-port definitions: button bit indices and the all-released
// serial pattern.
package nes_ctlr_port_pkg;

    typedef enum logic [2:0] {
        BtnA      = 3'd0,
        BtnB      = 3'd1,
        BtnSelect = 3'd2,
        BtnStart  = 3'd3,
        BtnUp     = 3'd4,
        BtnDown   = 3'd5,
        BtnLeft   = 3'd6,
        BtnRight  = 3'd7
    } ctlr_btn_e;

    localparam int unsigned CtlrNumBtns   = 8;
    localparam logic [7:0]  CTLR_RELEASED = 8'hFF;

endpackage

// File: rtl/nes_ctlr_port_btn_debounce.sv
// One-bit 2-flop synchronizer followed by a stability debouncer.
// DEBOUNCE_CYCLES = 0 leaves only the synchronizer.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_i,
    output logic deb_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw_i};
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_sync_only
        assign deb_o = sync_q[1];
    end else begin : g_debounce
        localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            deb_q, deb_d;

        // The value flips on the DEBOUNCE_CYCLES-th consecutive differing clock,
        // so the counter never passes DEBOUNCE_CYCLES-1.
        always_comb begin
            cnt_d = cnt_q;
            deb_d = deb_q;
            if (sync_q[1] == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d = '0;
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign deb_o = deb_q;
    end

endmodule

// File: rtl/nes_ctlr_port.sv
// NES standard controller responder: debounced buttons, optional A/B turbo,
// and the 4021-style latch/shift serial interface.
module nes_ctlr_port
    import nes_ctlr_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TURBO_DIV       = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clock_en_i,
    input  logic       frame_tick_i,
    input  logic [7:0] buttons_raw_i,
    input  logic [1:0] turbo_en_i,
    input  logic       ctlr_latch_i,
    input  logic       ctlr_pulse_i,
    output logic       ctlr_data_o,
    output logic [7:0] btn_state_o
);

    localparam int unsigned FrameW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [7:0]        btn_deb;
    logic [1:0]        turbo_sync;
    logic [7:0]        btn_q, btn_d;
    logic [7:0]        sr_q, sr_d;
    logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
    logic              turbo_phase_q, turbo_phase_d;

    for (genvar i = 0; i < CtlrNumBtns; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clock  (clock),
            .reset_n(reset_n),
            .raw_i  (buttons_raw_i[i]),
            .deb_o  (btn_deb[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_turbo
        btn_debounce #(
            .DEBOUNCE_CYCLES(0)
        ) u_turbo_sync (
            .clock  (clock),
            .reset_n(reset_n),
            .raw_i  (turbo_en_i[i]),
            .deb_o  (turbo_sync[i])
        );
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        turbo_phase_d = turbo_phase_q;
        if (frame_tick_i) begin
            if (frame_cnt_q == FrameW'(TURBO_DIV - 1)) begin
                frame_cnt_d   = '0;
                turbo_phase_d = ~turbo_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        btn_d       = btn_deb;
        btn_d[BtnA] = btn_deb[BtnA] & (~turbo_sync[0] | turbo_phase_q);
        btn_d[BtnB] = btn_deb[BtnB] & (~turbo_sync[1] | turbo_phase_q);
    end

    // Latch has priority: a pulse while the strobe is high never shifts.
    always_comb begin
        sr_d = sr_q;
        if (clock_en_i) begin
            if (ctlr_latch_i) begin
                sr_d = ~btn_q;
            end else if (ctlr_pulse_i) begin
                sr_d = {1'b1, sr_q[7:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q   <= '0;
            turbo_phase_q <= 1'b1;
            btn_q         <= '0;
            sr_q          <= CTLR_RELEASED;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            turbo_phase_q <= turbo_phase_d;
            btn_q         <= btn_d;
            sr_q          <= sr_d;
        end
    end

    assign ctlr_data_o = sr_q[0];
    assign btn_state_o = btn_q;

endmodule

// File: tb/tb_nes_ctlr_port.sv
// Bench for nes_ctlr_port: serial reads are scored against a queue of expected
// bits filled at each latch.
module tb_nes_ctlr_port;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clock_en;
    logic       frame_tick;
    logic [7:0] buttons_raw;
    logic [1:0] turbo_en;
    logic       ctlr_latch;
    logic       ctlr_pulse;
    logic       ctlr_data;
    logic [7:0] btn_state;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    logic        exp_q[$];

    always #5 clock = ~clock;

    nes_ctlr_port #(
        .DEBOUNCE_CYCLES(16),
        .TURBO_DIV      (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clock_en_i   (clock_en),
        .frame_tick_i (frame_tick),
        .buttons_raw_i(buttons_raw),
        .turbo_en_i   (turbo_en),
        .ctlr_latch_i (ctlr_latch),
        .ctlr_pulse_i (ctlr_pulse),
        .ctlr_data_o  (ctlr_data),
        .btn_state_o  (btn_state)
    );

    // clock_en: one cycle in three, settled shortly after each rising edge.
    initial begin : en_gen
        int c;
        c = 0;
        clock_en = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            clock_en = (c == 0);
            c = (c + 1) % 3;
        end
    end

    task automatic wait_en();
        int n;
        n = 0;
        @(negedge clock);
        while (!clock_en && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!clock_en) begin
            chk_cnt++;
            $display("FAIL wait_en: clock_en=%b required 1", clock_en);
        end
    endtask

    task automatic wait_btn(input int bit_idx, input logic val, input string tag);
        int n;
        n = 0;
        while (btn_state[bit_idx] !== val && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (btn_state[bit_idx] !== val) begin
            chk_cnt++;
            $display("FAIL %s timeout: btn_state[%0d]=%b required %b", tag, bit_idx,
                     btn_state[bit_idx], val);
        end
    endtask

    task automatic latch_snapshot(input logic [7:0] exp_btn);
        wait_en();
        ctlr_latch = 1'b1;
        @(negedge clock);
        ctlr_latch = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(~exp_btn[i]);
    endtask

    task automatic read_bit(input string tag);
        logic e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        wait_en();
        chk_cnt++;
        if (ctlr_data !== e) $display("FAIL %s: ctlr_data=%b expected %b", tag, ctlr_data, e);
        else pass_cnt++;
        ctlr_pulse = 1'b1;
        @(negedge clock);
        ctlr_pulse = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk_cnt++;
        if (ctlr_data !== 1'b1) $display("FAIL reset_data: ctlr_data=%b expected 1", ctlr_data);
        else pass_cnt++;
        chk_cnt++;
        if (btn_state !== 8'h00) $display("FAIL reset_btn: btn_state=%h expected 00", btn_state);
        else pass_cnt++;
        latch_snapshot(8'h00);
        for (int i = 0; i < 8; i++) read_bit("reset_read");
    endtask

    task automatic test_buttons();
        buttons_raw = 8'h09;
        repeat (25) @(negedge clock);
        chk_cnt++;
        if (btn_state !== 8'h09) $display("FAIL btn_09: btn_state=%h expected 09", btn_state);
        else pass_cnt++;
        latch_snapshot(8'h09);
        for (int i = 0; i < 10; i++) read_bit("read_09");
    endtask

    task automatic test_bounce();
        int early;
        buttons_raw = 8'h00;
        repeat (25) @(negedge clock);
        early = 0;
        for (int t = 0; t < 20; t++) begin
            buttons_raw[4] = ~buttons_raw[4];
            repeat (5) begin
                @(negedge clock);
                if (btn_state[4] !== 1'b0) early++;
            end
        end
        chk_cnt++;
        if (early != 0) $display("FAIL bounce_hold: btn_state[4] high %0d times expected 0", early);
        else pass_cnt++;
        buttons_raw[4] = 1'b1;
        repeat (18) @(negedge clock);
        chk_cnt++;
        if (btn_state[4] !== 1'b0) $display("FAIL bounce_18: btn_state[4]=%b expected 0", btn_state[4]);
        else pass_cnt++;
        @(negedge clock);
        chk_cnt++;
        if (btn_state[4] !== 1'b1) $display("FAIL bounce_19: btn_state[4]=%b expected 1", btn_state[4]);
        else pass_cnt++;
        buttons_raw = 8'h00;
        repeat (25) @(negedge clock);
    endtask

    task automatic test_latch_live();
        ctlr_latch = 1'b1;
        buttons_raw[0] = 1'b1;
        wait_btn(0, 1'b1, "live_press");
        wait_en();
        @(negedge clock);
        chk_cnt++;
        if (ctlr_data !== 1'b0) $display("FAIL live_press: ctlr_data=%b expected 0", ctlr_data);
        else pass_cnt++;
        buttons_raw[0] = 1'b0;
        wait_btn(0, 1'b0, "live_release");
        wait_en();
        @(negedge clock);
        chk_cnt++;
        if (ctlr_data !== 1'b1) $display("FAIL live_release: ctlr_data=%b expected 1", ctlr_data);
        else pass_cnt++;
        buttons_raw = 8'h21;
        repeat (25) @(negedge clock);
        wait_en();
        ctlr_pulse = 1'b1;
        @(negedge clock);
        ctlr_pulse = 1'b0;
        ctlr_latch = 1'b0;
        chk_cnt++;
        if (ctlr_data !== 1'b0) $display("FAIL latch_pulse: ctlr_data=%b expected 0", ctlr_data);
        else pass_cnt++;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(~buttons_raw[i]);
        for (int i = 0; i < 9; i++) read_bit("read_after_live");
    endtask

    task automatic test_reset_mid();
        buttons_raw = 8'h09;
        repeat (25) @(negedge clock);
        latch_snapshot(8'h09);
        for (int i = 0; i < 3; i++) read_bit("pre_reset_read");
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (ctlr_data !== 1'b1) $display("FAIL mid_reset_data: ctlr_data=%b expected 1", ctlr_data);
        else pass_cnt++;
        chk_cnt++;
        if (btn_state !== 8'h00) $display("FAIL mid_reset_btn: btn_state=%h expected 00", btn_state);
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        latch_snapshot(8'h00);
        for (int i = 0; i < 8; i++) read_bit("post_reset_fresh");
        repeat (25) @(negedge clock);
        latch_snapshot(8'h09);
        for (int i = 0; i < 8; i++) read_bit("post_reset_held");
    endtask

    task automatic test_turbo();
        logic exp_a;
        buttons_raw = 8'h03;
        turbo_en = 2'b01;
        repeat (25) @(negedge clock);
        for (int n = 0; n < 16; n++) begin
            exp_a = (((n / 4) % 2) == 0);
            chk_cnt++;
            if (btn_state[0] !== exp_a)
                $display("FAIL turbo_a frame %0d: btn_state[0]=%b expected %b", n, btn_state[0], exp_a);
            else pass_cnt++;
            chk_cnt++;
            if (btn_state[1] !== 1'b1)
                $display("FAIL turbo_b frame %0d: btn_state[1]=%b expected 1", n, btn_state[1]);
            else pass_cnt++;
            frame_tick = 1'b1;
            @(negedge clock);
            frame_tick = 1'b0;
            repeat (3) @(negedge clock);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_tick  = 1'b0;
        buttons_raw = 8'h00;
        turbo_en    = 2'b00;
        ctlr_latch  = 1'b0;
        ctlr_pulse  = 1'b0;
        test_reset();
        test_buttons();
        test_bounce();
        test_latch_live();
        test_reset_mid();
        test_turbo();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
